// File: rtl/mem_responder.sv
// Word-wide memory responder: valid/ready request, programmable wait states,
// little-endian byte array access, and a one-cycle registered response pulse.
module mem_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_req_ready,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    localparam int         DEPTH   = 1 << ADDR_BITS;
    localparam logic [3:0] LP_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    logic [3:0]  r_wait_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_acc_rdata;
    logic        r_acc_err;
    logic [7:0]  r_mem [0:DEPTH-1];

    logic                 w_accept;
    logic                 w_enter_resp;
    logic                 w_acc_we;
    logic [31:0]          w_acc_addr;
    logic [31:0]          w_acc_wdata;
    logic                 w_acc_err;
    logic [ADDR_BITS-3:0] w_word;
    logic [31:0]          w_rd_word;

    assign w_accept = (r_state == S_IDLE) && i_req_valid && o_req_ready;

    // With zero wait states the access happens on the accepting edge itself,
    // so the request fields must come straight from the inputs in IDLE.
    assign w_enter_resp = (WAIT_CYCLES == 0) ? w_accept
                        : ((r_state == S_WAIT) && (r_wait_cnt == LP_LAST));
    assign w_acc_we     = (r_state == S_IDLE) ? i_req_we    : r_we;
    assign w_acc_addr   = (r_state == S_IDLE) ? i_req_addr  : r_addr;
    assign w_acc_wdata  = (r_state == S_IDLE) ? i_req_wdata : r_wdata;
    assign w_acc_err    = (w_acc_addr[1:0] != 2'b00) || ((w_acc_addr >> ADDR_BITS) != 32'd0);
    assign w_word       = w_acc_addr[ADDR_BITS-1:2];
    assign w_rd_word    = {r_mem[{w_word, 2'b11}], r_mem[{w_word, 2'b10}],
                           r_mem[{w_word, 2'b01}], r_mem[{w_word, 2'b00}]};

    // Array is deliberately not reset; a reset in flight suppresses the write.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_enter_resp && w_acc_we && !w_acc_err) begin
            r_mem[{w_word, 2'b00}] <= w_acc_wdata[7:0];
            r_mem[{w_word, 2'b01}] <= w_acc_wdata[15:8];
            r_mem[{w_word, 2'b10}] <= w_acc_wdata[23:16];
            r_mem[{w_word, 2'b11}] <= w_acc_wdata[31:24];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_acc_rdata <= 32'd0;
            r_acc_err   <= 1'b0;
            o_req_ready <= 1'b1;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= 32'd0;
            o_rsp_err   <= 1'b0;
        end else begin
            o_rsp_valid <= 1'b0;
            if (w_enter_resp) begin
                r_acc_rdata <= (w_acc_we || w_acc_err) ? 32'd0 : w_rd_word;
                r_acc_err   <= w_acc_err;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we        <= i_req_we;
                        r_addr      <= i_req_addr;
                        r_wdata     <= i_req_wdata;
                        r_wait_cnt  <= 4'd0;
                        o_req_ready <= 1'b0;
                        r_state     <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == LP_LAST) begin
                        r_state <= S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                S_RESP: begin
                    // Response fields publish one cycle after the access edge.
                    o_rsp_valid <= 1'b1;
                    o_rsp_rdata <= r_acc_rdata;
                    o_rsp_err   <= r_acc_err;
                    o_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state     <= S_IDLE;
                    o_req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
